// File: rtl/reg_file_dumper_if.sv
// Interface bundle for reg_file_dumper.
// It carries the start request, the register-file read port, the output
// valid/ready stream and the status flags. Signal prefixes are named from the
// dumper's point of view: i_ is an input to the dumper and o_ is an output.
interface reg_file_dumper_if #(
  parameter int W = 8,
  parameter int A = 4
);
  logic         i_start;
  logic [A-1:0] i_start_addr;
  logic [A-1:0] i_end_addr;
  logic [A-1:0] o_raddr;
  logic [W-1:0] i_rdata;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_data;
  logic [A-1:0] o_addr;
  logic         o_busy;
  logic         o_done;

  // Modport for the dumper itself.
  modport slave (
    input  i_start, i_start_addr, i_end_addr, i_rdata, i_ready,
    output o_raddr, o_valid, o_data, o_addr, o_busy, o_done
  );

  // Modport for the harness or debug logic that drives the dumper.
  modport master (
    output i_start, i_start_addr, i_end_addr, i_rdata, i_ready,
    input  o_raddr, o_valid, o_data, o_addr, o_busy, o_done
  );
endinterface

// File: rtl/reg_file_dumper.sv
// reg_file_dumper: walks an inclusive, wrapping address range through a single
// register-file read port. Each word is streamed out on a valid/ready port and
// tagged with the address it was read from.
// Optional feature macro: REG_DUMP_SKIP_ZERO_EN. When it is defined,
// zero-valued registers are skipped and are not emitted.
module reg_file_dumper #(
  parameter int W = 8,
  parameter int A = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  reg_file_dumper_if.slave   bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]   r_state;
  logic [A-1:0] r_ptr;
  logic [A-1:0] r_end;
  logic         r_valid;
  logic [W-1:0] r_data;
  logic [A-1:0] r_addr;
  logic         r_busy;
  logic         r_done;

  logic [1:0]   w_state_nxt;
  logic [A-1:0] w_ptr_nxt;
  logic [A-1:0] w_end_nxt;
  logic         w_valid_nxt;
  logic [W-1:0] w_data_nxt;
  logic [A-1:0] w_addr_nxt;

  // Next-state and datapath decode. Everything holds unless the state acts on it.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_end_nxt   = r_end;
    w_valid_nxt = r_valid;
    w_data_nxt  = r_data;
    w_addr_nxt  = r_addr;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_start) begin
          w_ptr_nxt   = bus.i_start_addr;
          w_end_nxt   = bus.i_end_addr;
          w_state_nxt = ST_FETCH;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FETCH: begin
`ifdef REG_DUMP_SKIP_ZERO_EN
        if (bus.i_rdata == {W{1'b0}}) begin
          // Skip this register: one cycle per skipped address.
          w_valid_nxt = 1'b0;
          if (r_ptr == r_end) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_ptr_nxt   = r_ptr + A'(1);
            w_state_nxt = ST_FETCH;
          end
        end else begin
          w_data_nxt  = bus.i_rdata;
          w_addr_nxt  = r_ptr;
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_SEND;
        end
`else
        w_data_nxt  = bus.i_rdata;
        w_addr_nxt  = r_ptr;
        w_valid_nxt = 1'b1;
        w_state_nxt = ST_SEND;
`endif
      end
      ST_SEND: begin
        if (r_valid && bus.i_ready) begin
          w_valid_nxt = 1'b0;
          if (r_ptr == r_end) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_ptr_nxt   = r_ptr + A'(1);
            w_state_nxt = ST_FETCH;
          end
        end else begin
          w_state_nxt = ST_SEND;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers. Busy and Done are registered from the next state,
  // so they line up with the state that they describe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= {A{1'b0}};
      r_end   <= {A{1'b0}};
      r_valid <= 1'b0;
      r_data  <= {W{1'b0}};
      r_addr  <= {A{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_end   <= w_end_nxt;
      r_valid <= w_valid_nxt;
      r_data  <= w_data_nxt;
      r_addr  <= w_addr_nxt;
      r_busy  <= (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_SEND);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  assign bus.o_raddr = r_ptr;
  assign bus.o_valid = r_valid;
  assign bus.o_data  = r_data;
  assign bus.o_addr  = r_addr;
  assign bus.o_busy  = r_busy;
  assign bus.o_done  = r_done;

endmodule

// File: tb/tb_reg_file_dumper.sv
// Testbench for reg_file_dumper. Dump scenarios are listed in a vector table,
// and hand-written sequences cover zero-valued registers and asynchronous reset.
module tb_reg_file_dumper;
  localparam int W = 8;
  localparam int A = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_file_dumper_if #(.W(W), .A(A)) bus ();

  reg_file_dumper #(.W(W), .A(A)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  logic [W-1:0] mem [0:15];
  assign bus.i_rdata = mem[bus.o_raddr];

  int n_tests = 0;
  int n_fail  = 0;

  logic [A-1:0] got_addr [$];
  logic [W-1:0] got_data [$];
  int           got_first [$];
  int           done_at;

  typedef struct {
    logic [3:0] sa;
    logic [3:0] ea;
    int         stall;
    bit         repulse;
    int         exp_n;
    int         exp_done;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one dump and records every accepted word and the cycle on which Done appeared.
  task automatic run_dump(input logic [A-1:0] sa, input logic [A-1:0] ea,
                          input int stall, input bit repulse);
    int idx;
    int scnt;
    bit held;
    logic [A-1:0] ha;
    logic [W-1:0] hd;
    got_addr.delete();
    got_data.delete();
    got_first.delete();
    done_at = -1;
    @(negedge clk);
    bus.i_start      = 1'b1;
    bus.i_start_addr = sa;
    bus.i_end_addr   = ea;
    bus.i_ready      = (stall == 0);
    @(posedge clk);
    #1 bus.i_start = 1'b0;
    idx = 0;
    scnt = 0;
    held = 1'b0;
    ha = '0;
    hd = '0;
    while (idx < 400) begin
      @(negedge clk);
      idx++;
      if (repulse && idx == 1) begin
        bus.i_start      = 1'b1;
        bus.i_start_addr = 4'd0;
        bus.i_end_addr   = 4'd15;
      end
      if (repulse && idx == 3) bus.i_start = 1'b0;
      if (done_at >= 0) begin
        check("done_one_cycle", {31'd0, bus.o_done}, 32'd0);
        check("busy_after_done", {31'd0, bus.o_busy}, 32'd0);
        break;
      end
      if (bus.o_done) begin
        done_at = idx;
        check("busy_in_done", {31'd0, bus.o_busy}, 32'd0);
        continue;
      end
      check("busy_active", {31'd0, bus.o_busy}, 32'd1);
      if (bus.o_valid) begin
        if (!held) begin
          held = 1'b1;
          ha = bus.o_addr;
          hd = bus.o_data;
          got_first.push_back(idx);
        end else begin
          check("hold_addr", {28'd0, bus.o_addr}, {28'd0, ha});
          check("hold_data", {24'd0, bus.o_data}, {24'd0, hd});
        end
        if (scnt < stall) begin
          scnt++;
          bus.i_ready = 1'b0;
        end else begin
          bus.i_ready = 1'b1;
          got_addr.push_back(ha);
          got_data.push_back(hd);
          scnt = 0;
          held = 1'b0;
        end
      end else begin
        bus.i_ready = (stall == 0);
      end
    end
    if (done_at < 0) check("done_timeout", 32'd0, 32'd1);
    bus.i_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] ea4;
    bus.i_start      = 1'b0;
    bus.i_start_addr = '0;
    bus.i_end_addr   = '0;
    bus.i_ready      = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);

    vecs[0] = '{4'd0,  4'd15, 0, 1'b0, 16, 33};
    vecs[1] = '{4'd3,  4'd5,  5, 1'b0, 3,  22};
    vecs[2] = '{4'd14, 4'd1,  0, 1'b0, 4,  9};
    vecs[3] = '{4'd7,  4'd7,  0, 1'b1, 1,  3};
    vecs[4] = '{4'd9,  4'd10, 1, 1'b0, 2,  7};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    check("rst_busy",  {31'd0, bus.o_busy},  32'd0);
    check("rst_done",  {31'd0, bus.o_done},  32'd0);
    check("rst_raddr", {28'd0, bus.o_raddr}, 32'd0);
    check("rst_data",  {24'd0, bus.o_data},  32'd0);
    check("rst_addr",  {28'd0, bus.o_addr},  32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven dumps
    for (int v = 0; v < 5; v++) begin
      run_dump(vecs[v].sa, vecs[v].ea, vecs[v].stall, vecs[v].repulse);
      check("word_count", got_addr.size(), vecs[v].exp_n);
      check("done_cycle", done_at, vecs[v].exp_done);
      for (int k = 0; k < got_addr.size() && k < vecs[v].exp_n; k++) begin
        ea4 = vecs[v].sa + 4'(k);
        check("word_addr", {28'd0, got_addr[k]}, {28'd0, ea4});
        check("word_data", {24'd0, got_data[k]}, {24'd0, 4'h1, ea4});
        check("word_time", got_first[k], 2 + k * (vecs[v].stall + 2));
      end
      repeat (2) @(negedge clk);
    end

    // Zero-valued register in the middle of a range
    mem[5] = 8'h00;
    run_dump(4'd4, 4'd6, 0, 1'b0);
`ifdef REG_DUMP_SKIP_ZERO_EN
    check("z_count", got_addr.size(), 2);
    check("z_done", done_at, 6);
    if (got_addr.size() == 2) begin
      check("z_a0", {28'd0, got_addr[0]}, 32'd4);
      check("z_d0", {24'd0, got_data[0]}, 32'h14);
      check("z_a1", {28'd0, got_addr[1]}, 32'd6);
      check("z_d1", {24'd0, got_data[1]}, 32'h16);
    end
    // Sparse register file: only registers 2 and 4 are nonzero.
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[2] = 8'hAA;
    mem[4] = 8'h55;
    run_dump(4'd0, 4'd15, 0, 1'b0);
    check("sk_count", got_addr.size(), 2);
    check("sk_done", done_at, 19);
    if (got_addr.size() == 2) begin
      check("sk_a0", {28'd0, got_addr[0]}, 32'd2);
      check("sk_d0", {24'd0, got_data[0]}, 32'hAA);
      check("sk_a1", {28'd0, got_addr[1]}, 32'd4);
      check("sk_d1", {24'd0, got_data[1]}, 32'h55);
    end
    run_dump(4'd5, 4'd8, 0, 1'b0);
    check("allzero_count", got_addr.size(), 0);
    check("allzero_done", done_at, 5);
`else
    check("z_count", got_addr.size(), 3);
    check("z_done", done_at, 7);
    if (got_addr.size() == 3) begin
      check("z_a1", {28'd0, got_addr[1]}, 32'd5);
      check("z_d1", {24'd0, got_data[1]}, 32'h00);
      check("z_d2", {24'd0, got_data[2]}, 32'h16);
    end
`endif
    for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
    repeat (2) @(negedge clk);

    // Asynchronous reset while a word is waiting in SEND
    @(negedge clk);
    bus.i_start      = 1'b1;
    bus.i_start_addr = 4'd6;
    bus.i_end_addr   = 4'd12;
    bus.i_ready      = 1'b0;
    @(posedge clk);
    #1 bus.i_start = 1'b0;
    repeat (2) @(negedge clk);
    check("ar_valid_before", {31'd0, bus.o_valid}, 32'd1);
    check("ar_addr_before", {28'd0, bus.o_addr}, 32'd6);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", {31'd0, bus.o_valid}, 32'd0);
    check("ar_busy",  {31'd0, bus.o_busy},  32'd0);
    check("ar_done",  {31'd0, bus.o_done},  32'd0);
    check("ar_raddr", {28'd0, bus.o_raddr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("ar_idle_valid", {31'd0, bus.o_valid}, 32'd0);
      check("ar_idle_busy",  {31'd0, bus.o_busy},  32'd0);
      check("ar_idle_raddr", {28'd0, bus.o_raddr}, 32'd0);
    end
    bus.i_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
